l1_dcache: RTL
==============

# l1_dcache

Direct-mapped, write-through, read-allocate data cache with one-word lines. Sits between the CPU-side request path and the backing memory port that the memory controller drives. It resolves cacheable read hits locally and forwards every miss, uncacheable read and write to backing memory. It also exposes hit/miss status and counters for the controller and debug.

## Interface
Parameters:
- INDEX_BITS, 6, line-index width; the cache has 2^INDEX_BITS lines of one 32-bit word each.
- TIMEOUT, 255, maximum backing-memory wait in cycles before forced completion (1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present; held until req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wdata  in  32  write data.
- cache_enable  in  1  request address is cacheable.
- flush  in  1  one-cycle pulse that invalidates all lines.
- req_rdata  out  32  read data, valid while req_ready=1.
- req_ready  out  1  one-cycle completion pulse.
- cache_hit  out  1  registered; 1 during the req_ready cycle of a read served from the cache.
- req_err  out  1  1 during the req_ready cycle of a timed-out access.
- bk_read / bk_write  out  1  backing-memory strobes.
- bk_addr  out  32  backing address, word-aligned (bits [1:0]=0).
- bk_wdata  out  32  backing write data.
- bk_rdata  in  32  backing read data, sampled when bk_ready=1.
- bk_ready  in  1  backing access complete.
- hit_count / miss_count  out  16  saturating statistics.

## Operation
- Address split: tag = addr[31:INDEX_BITS+2], index = addr[INDEX_BITS+1:2]. Each line holds a valid bit, a tag and a 32-bit data word.
- Reset clears all valid bits, counters, outputs and registered request fields to 0. State resets to IDLE.
- States are IDLE, BK_RD, BK_WR and RESP.
- IDLE:
  - A pending flush clears every valid bit this cycle and blocks acceptance. Flush has priority over a new request.
  - Otherwise, when req_valid=1, the block registers addr, wdata, write and enable.
  - Read with cache_enable=1, valid=1 and tag match: the line data is registered into req_rdata, cache_hit is set, hit_count increments, and the state goes to RESP.
  - Other read: the state goes to BK_RD. miss_count increments only when cache_enable=1.
  - Write: the state goes to BK_WR.
- BK_RD: bk_read=1 with the registered address.
  - On bk_ready: req_rdata takes bk_rdata. If the request was cacheable, the line is filled (valid=1, tag, data). The state goes to RESP.
- BK_WR: bk_write=1 with the registered address and data.
  - On bk_ready: if the request was cacheable and hits a valid line with the same tag, that line's data is updated. A write miss does not allocate. The state goes to RESP.
- Timeout: a wait counter increments each BK_RD/BK_WR cycle with bk_ready=0. When it reaches TIMEOUT:
  - req_err is set and the state goes to RESP.
  - Read data is 32'hDEADBEEF, with no fill and no line update.
  - The counter clears on entering BK_RD or BK_WR.
- RESP: req_ready=1 for exactly one cycle, then IDLE. req_valid is ignored in RESP. The requester deasserts req_valid on the edge where it samples req_ready=1.
- Flush handling:
  - A flush pulse outside IDLE sets a pending flag, which is applied at the next IDLE.
  - A flush during BK_RD does not cancel that access's fill. The fill occurs, and the subsequent flush invalidates it.
- Counters saturate at 16'hFFFF.

## Timing
- Read hit: req_ready occurs 1 cycle after acceptance (accept edge, then RESP).
- Miss or write: bk strobe is asserted in the cycle after acceptance. req_ready follows 1 cycle after the bk_ready edge. Minimum latency is 2 cycles with bk_ready held at 1.
- bk_read and bk_write are never both 1. Strobes deassert in RESP.
- cache_hit, req_err and req_rdata hold their values only during the req_ready cycle, and are 0 otherwise.
- Reset mid-access: outputs drop to 0 immediately. Any in-flight fill is discarded.
- Back-to-back requests: the next request can be accepted on the cycle after RESP, giving a 2-cycle issue interval for hits.

## Test plan
- Cold read of 0x00000100 (cacheable), bk_rdata=0x12345678, bk_ready on the 3rd cycle. Expect: miss_count=1, req_rdata=0x12345678, cache_hit=0. A re-read is a hit with 1-cycle latency, no bk_read, and hit_count=1.
- Write 0xCAFEF00D to 0x100 after the fill. Expect: bk_write with bk_addr=0x100 and bk_wdata=0xCAFEF00D. A subsequent read of 0x100 hits and returns 0xCAFEF00D.
- Conflict: with INDEX_BITS=6, read 0x100 then 0x200 (index 0 for both, different tag). Expect: the second read misses. Re-reading 0x100 misses again and miss_count=3.
- Uncacheable read (cache_enable=0) of 0xF0000010, repeated twice. Expect: both reads go to backing memory, no fill, and counters unchanged.
- Timeout: bk_ready held at 0. Expect: req_ready exactly TIMEOUT cycles after bk_read rises, req_err=1, req_rdata=0xDEADBEEF. A later read of the same address still misses.
- Flush pulse during BK_RD of 0x100. Expect: the fill completes, the flush applies at IDLE, and the next read of 0x100 misses.

Source files
------------

// File: rtl/l1_dcache.sv
// Direct-mapped, write-through, read-allocate L1 data cache with one-word lines.
// Read hits complete locally; misses, uncacheable reads and all writes go to backing memory.
module l1_dcache #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        cache_enable,
  input  logic        flush,
  output logic [31:0] req_rdata,
  output logic        req_ready,
  output logic        cache_hit,
  output logic        req_err,
  output logic        bk_read,
  output logic        bk_write,
  output logic [31:0] bk_addr,
  output logic [31:0] bk_wdata,
  input  logic [31:0] bk_rdata,
  input  logic        bk_ready,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned TagBits = 30 - INDEX_BITS;

  typedef enum logic [1:0] {StIdle, StBkRd, StBkWr, StResp} state_e;

  state_e state_q, state_d;

  logic [Lines-1:0]   valid_q;
  logic [TagBits-1:0] tag_mem  [Lines];
  logic [31:0]        data_mem [Lines];

  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic        enable_q;
  logic [7:0]  wait_q;
  logic        flush_pend_q;
  logic [31:0] rdata_q;
  logic        hit_q;
  logic        err_q;
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  logic [INDEX_BITS-1:0] req_idx, q_idx;
  logic [TagBits-1:0]    req_tag, q_tag;
  logic                  lookup_hit, line_match;
  logic                  flush_now, accept, rd_hit, bk_busy, timed_out;
  logic [8:0]            wait_inc;
  logic                  unused_addr_bits;

  assign req_idx          = req_addr[INDEX_BITS+1:2];
  assign req_tag          = req_addr[31:INDEX_BITS+2];
  assign q_idx            = addr_q[INDEX_BITS+1:2];
  assign q_tag            = addr_q[31:INDEX_BITS+2];
  assign unused_addr_bits = ^req_addr[1:0];

  assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign line_match = valid_q[q_idx] && (tag_mem[q_idx] == q_tag);

  // A pending or live flush owns the IDLE cycle; no request is accepted alongside it.
  assign flush_now = flush | flush_pend_q;
  assign accept    = (state_q == StIdle) && !flush_now && req_valid;
  assign rd_hit    = accept && !req_write && cache_enable && lookup_hit;
  assign bk_busy   = (state_q == StBkRd) || (state_q == StBkWr);
  assign wait_inc  = {1'b0, wait_q} + 9'd1;
  assign timed_out = bk_busy && !bk_ready && (wait_inc == 9'(TIMEOUT));

  assign req_ready  = (state_q == StResp);
  assign bk_read    = (state_q == StBkRd);
  assign bk_write   = (state_q == StBkWr);
  assign bk_addr    = {addr_q, 2'b00};
  assign bk_wdata   = wdata_q;
  assign req_rdata  = rdata_q;
  assign cache_hit  = hit_q;
  assign req_err    = err_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_write)   state_d = StBkWr;
          else if (rd_hit) state_d = StResp;
          else             state_d = StBkRd;
        end
      end
      StBkRd, StBkWr: if (bk_ready || timed_out) state_d = StResp;
      StResp:         state_d = StIdle;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      enable_q     <= 1'b0;
      wait_q       <= '0;
      flush_pend_q <= 1'b0;
      rdata_q      <= '0;
      hit_q        <= 1'b0;
      err_q        <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (state_q == StIdle) begin
        if (flush_now) begin
          valid_q      <= '0;
          flush_pend_q <= 1'b0;
        end
      end else if (flush) begin
        flush_pend_q <= 1'b1;
      end

      if (accept) begin
        addr_q   <= req_addr[31:2];
        wdata_q  <= req_wdata;
        enable_q <= cache_enable;
        wait_q   <= '0;
        if (rd_hit) begin
          hit_cnt_q <= (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
        end else if (!req_write && cache_enable) begin
          miss_cnt_q <= (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
        end
      end else if (bk_busy && !bk_ready) begin
        wait_q <= wait_inc[7:0];
      end

      if (rd_hit) begin
        rdata_q <= data_mem[req_idx];
        hit_q   <= 1'b1;
      end else if (state_q == StBkRd && bk_ready) begin
        rdata_q <= bk_rdata;
        if (enable_q) valid_q[q_idx] <= 1'b1;
      end else if (timed_out) begin
        rdata_q <= 32'hDEAD_BEEF;
        err_q   <= 1'b1;
      end else if (state_q == StResp) begin
        rdata_q <= '0;
        hit_q   <= 1'b0;
        err_q   <= 1'b0;
      end
    end
  end

  // Line storage carries no reset; valid_q alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (state_q == StBkRd && bk_ready && enable_q) begin
      tag_mem[q_idx]  <= q_tag;
      data_mem[q_idx] <= bk_rdata;
    end else if (state_q == StBkWr && bk_ready && enable_q && line_match) begin
      data_mem[q_idx] <= wdata_q;
    end
  end

endmodule
